input_debouncer: RTL and testbench
==================================

# input_debouncer

Upstream conditioning stage for the edge detector. It takes a raw asynchronous level input such as a push-button, switch or external strobe and synchronises it into `clk`. It rejects bounces and glitches shorter than a programmable number of cycles and outputs a clean, registered level that drives the edge detector's `x` input directly. It also reports whether the level is currently settled and counts rejected glitches for debug.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count; legal range ≥2.
- `DEBOUNCE_CYCLES`, default 16: consecutive identical synchronized samples needed to accept a new level; legal range ≥2.
- `RESET_LEVEL`, default 0: level assumed during and after reset; 1-bit.
- `clk`, input, 1: clock.
- `reset`, input, 1: synchronous, active-high reset.
- `x_in`, input, 1: raw asynchronous input.
- `x_clean`, output, 1: debounced level; registered; feeds the edge detector's `x`.
- `stable`, output, 1: 1 when the FSM is in a STABLE state, 0 while checking a candidate change.
- `glitch_cnt`, output, 8: saturating count of rejected candidate changes.

## Operation
- Synchronizer: a chain of `SYNC_STAGES` flops.
  - `sync[0]` samples `x_in` every edge.
  - `s = sync[SYNC_STAGES-1]` is the only signal the FSM sees.
  - No logic sits between synchronizer flops.
- FSM states: STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW.
- Counter `cnt` has width `$clog2(DEBOUNCE_CYCLES)`.
- STABLE_LOW:
  - `s`=1 → CHECK_HIGH with `cnt`←1.
  - Otherwise stay, with `cnt`←0.
- CHECK_HIGH:
  - `s`=0 → STABLE_LOW, `cnt`←0, `glitch_cnt` increments.
  - `s`=1 and `cnt`==DEBOUNCE_CYCLES-1 → STABLE_HIGH, `x_clean`←1.
  - `s`=1 otherwise → `cnt`++.
- STABLE_HIGH and CHECK_LOW are mirror images of the above, with polarity inverted; acceptance sets `x_clean`←0.
- `x_clean` changes only on a STABLE→STABLE transition. It never toggles while the FSM is in a CHECK state.
- `stable` = (state is STABLE_LOW or STABLE_HIGH).
- `glitch_cnt` saturates at 255 and holds there. It is cleared only by reset.
- A reversion on the same edge that `cnt` would reach DEBOUNCE_CYCLES-1 counts as a reversion, not an acceptance. The `s` value sampled at that edge decides.

## Timing
- Reset (any cycle, including mid-CHECK) takes effect at the next edge:
  - All sync flops ← RESET_LEVEL.
  - State ← STABLE_LOW if RESET_LEVEL=0, else STABLE_HIGH.
  - `cnt`←0, `x_clean`←RESET_LEVEL, `stable`←1, `glitch_cnt`←0.
  - `x_in` is ignored while reset is high.
  - A check in progress is abandoned and is not counted as a glitch.
- Latency for a valid change: let `x_in` change before edge E and stay constant.
  - `s` reflects the new value after edge E+SYNC_STAGES-1.
  - The first FSM sample occurs at edge E+SYNC_STAGES.
  - `x_clean` updates after edge E+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - With defaults, that is 17 cycles after E.
- `stable` drops after edge E+SYNC_STAGES. It returns to 1 on the same edge that `x_clean` updates.
- Minimum accepted pulse width: DEBOUNCE_CYCLES cycles of stable `s`. Any shorter pulse is rejected and leaves `x_clean` unchanged.
- Back-to-back changes are allowed: after acceptance, the opposite check can begin on the very next edge.
- The edge detector sees at most one `x_clean` transition per DEBOUNCE_CYCLES cycles.

## Test plan
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0.
- **Reset:** hold `x_in`=1 during a 3-cycle reset → `x_clean`=0, `stable`=1 and `glitch_cnt`=0 throughout reset. After release, `x_clean` rises exactly 5 edges later.
- **Clean rise/fall:** `x_in` 0→1 before edge 10, held → `stable`=0 after edge 12, `x_clean`=1 and `stable`=1 after edge 15. Then 1→0 before edge 30 → `x_clean`=0 after edge 35.
- **Glitch rejection:** `x_in` high for 3 cycles then low → `x_clean` stays 0 and `glitch_cnt`=1. Bouncing 1,0,1,0,1 → `glitch_cnt`=2 and `x_clean`=0, then the final held 1 is accepted 4 samples later.
- **Last-sample reversion:** `s` held at 1 for 3 samples (`cnt`=3), then 0 on the 4th → back to STABLE_LOW, `x_clean`=0, `glitch_cnt` incremented.
- **Saturation:** generate 300 short glitches → `glitch_cnt` reaches 255 and holds; `x_clean` never changes.
- **Reset mid-check:** assert reset while in CHECK_HIGH with `cnt`=2 → after the edge, `x_clean`=0, `cnt`=0, `glitch_cnt`=0 and state STABLE_LOW.

Source files
------------

// File: rtl/input_debouncer.sv
// Synchronises a raw asynchronous level into clk and accepts a new level only after
// DEBOUNCE_CYCLES consecutive identical samples; counts rejected candidate changes.
module input_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x_in,
  output logic       x_clean,
  output logic       stable,
  output logic [7:0] glitch_cnt
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] GLITCH_MAX = 8'hFF;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   x_clean_q;
  logic                   stable_q;
  logic [7:0]             glitch_q;

  // Plain flop chain: no logic between stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], x_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce FSM; x_clean only moves on a CHECK -> opposite STABLE acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_LEVEL ? STABLE_HIGH : STABLE_LOW;
      cnt_q     <= '0;
      x_clean_q <= RESET_LEVEL;
      stable_q  <= 1'b1;
      glitch_q  <= '0;
    end else begin
      case (state_q)
        STABLE_LOW: begin
          if (s) begin
            state_q  <= CHECK_HIGH;
            cnt_q    <= CNT_W'(1);
            stable_q <= 1'b0;
          end else begin
            cnt_q <= '0;
          end
        end
        CHECK_HIGH: begin
          if (!s) begin
            state_q  <= STABLE_LOW;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            if (glitch_q != GLITCH_MAX) glitch_q <= glitch_q + 8'd1;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= STABLE_HIGH;
            cnt_q     <= '0;
            x_clean_q <= 1'b1;
            stable_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            state_q  <= CHECK_LOW;
            cnt_q    <= CNT_W'(1);
            stable_q <= 1'b0;
          end else begin
            cnt_q <= '0;
          end
        end
        CHECK_LOW: begin
          if (s) begin
            state_q  <= STABLE_HIGH;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            if (glitch_q != GLITCH_MAX) glitch_q <= glitch_q + 8'd1;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= STABLE_LOW;
            cnt_q     <= '0;
            x_clean_q <= 1'b0;
            stable_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= STABLE_LOW;
          cnt_q     <= '0;
          x_clean_q <= 1'b0;
          stable_q  <= 1'b1;
        end
      endcase
    end
  end

  assign x_clean    = x_clean_q;
  assign stable     = stable_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_LEVEL=0)
// with a run-length reference model feeding an expected-value queue.
module tb_input_debouncer;

  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;

  typedef struct packed {
    logic       x_clean;
    logic       stable;
    logic [7:0] glitch;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x_in = 1'b0;
  logic       x_clean;
  logic       stable;
  logic [7:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // Reference model state: sync pipeline, accepted level, run length of differing samples.
  logic [SS-1:0] m_sync = '0;
  logic          m_level = 1'b0;
  int            m_run = 0;
  int            m_glitch = 0;

  input_debouncer #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .RESET_LEVEL    (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .x_clean   (x_clean),
    .stable    (stable),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, predict post-edge outputs, then compare them after the edge.
  task automatic step(input logic xi, input logic rst);
    exp_t e;
    logic s;
    x_in  = xi;
    reset = rst;
    if (rst) begin
      m_sync   = '0;
      m_level  = 1'b0;
      m_run    = 0;
      m_glitch = 0;
    end else begin
      s = m_sync[SS-1];
      for (int i = SS - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = xi;
      if (s != m_level) begin
        m_run++;
        if (m_run == DC) begin
          m_level = s;
          m_run   = 0;
        end
      end else begin
        if (m_run > 0 && m_glitch < 255) m_glitch++;
        m_run = 0;
      end
    end
    e.x_clean = m_level;
    e.stable  = (m_run == 0);
    e.glitch  = 8'(m_glitch);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("model_x_clean", 8'(x_clean), 8'(e.x_clean));
    chk("model_stable", 8'(stable), 8'(e.stable));
    chk("model_glitch_cnt", glitch_cnt, e.glitch);
  endtask

  initial begin
    // Reset held with x_in high
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      chk("rst_x_clean", 8'(x_clean), 8'd0);
      chk("rst_stable", 8'(stable), 8'd1);
      chk("rst_glitch", glitch_cnt, 8'd0);
    end
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0);
      if (i == 5) chk("rel_before_rise", 8'(x_clean), 8'd0);
      if (i == 6) chk("rel_rise", 8'(x_clean), 8'd1);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk("settle_low", 8'(x_clean), 8'd0);

    // Clean rise and fall
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      if (i == 3) chk("rise_stable_drop", 8'(stable), 8'd0);
      if (i == 5) chk("rise_not_yet", 8'(x_clean), 8'd0);
      if (i == 6) begin
        chk("rise_x_clean", 8'(x_clean), 8'd1);
        chk("rise_stable_back", 8'(stable), 8'd1);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0);
      if (i == 5) chk("fall_not_yet", 8'(x_clean), 8'd1);
      if (i == 6) chk("fall_x_clean", 8'(x_clean), 8'd0);
    end

    // Three-sample pulse reverts on the last sample
    repeat (3) step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    chk("last_sample_glitch", glitch_cnt, 8'd1);
    chk("last_sample_x_clean", 8'(x_clean), 8'd0);

    // Bounce 1,0,1,0 then held 1
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b0);
      if (i == 5) chk("bounce_not_yet", 8'(x_clean), 8'd0);
      if (i == 6) chk("bounce_accept", 8'(x_clean), 8'd1);
    end
    chk("bounce_glitch", glitch_cnt, 8'd3);

    // Short low dip while high is rejected
    repeat (2) step(1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b0);
    chk("dip_glitch", glitch_cnt, 8'd4);
    chk("dip_x_clean", 8'(x_clean), 8'd1);
    repeat (8) step(1'b0, 1'b0);
    chk("dip_return_low", 8'(x_clean), 8'd0);

    // Saturation with 300 single-cycle glitches
    repeat (300) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    repeat (4) step(1'b0, 1'b0);
    chk("sat_glitch", glitch_cnt, 8'd255);
    chk("sat_x_clean", 8'(x_clean), 8'd0);

    // Reset in the middle of a high check
    repeat (4) step(1'b1, 1'b0);
    chk("midchk_stable", 8'(stable), 8'd0);
    step(1'b1, 1'b1);
    chk("midchk_x_clean", 8'(x_clean), 8'd0);
    chk("midchk_stable_rst", 8'(stable), 8'd1);
    chk("midchk_glitch", glitch_cnt, 8'd0);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0);
      if (i == 5) chk("midchk_restart_pre", 8'(x_clean), 8'd0);
      if (i == 6) chk("midchk_restart_rise", 8'(x_clean), 8'd1);
    end
    chk("midchk_no_glitch", glitch_cnt, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
